// File: rtl/alu_feeder_pkg.sv
// Shared types and helpers for the binary conv/pooling ALU feeder.
// Holds the FSM state encoding and the one-hot kernel-size decoding.
package alu_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD_W,
        FILL,
        STREAM,
        NEXT_ROW,
        DONE
    } feeder_state_t;

    localparam logic [4:0] K1 = 5'b00001;
    localparam logic [4:0] K2 = 5'b00010;
    localparam logic [4:0] K3 = 5'b00100;
    localparam logic [4:0] K4 = 5'b01000;
    localparam logic [4:0] K5 = 5'b10000;

    function automatic logic onehot_ok(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Returns 0 for anything that is not a legal one-hot kernel size.
    function automatic logic [2:0] kernel_dim(input logic [4:0] onehot);
        case (onehot)
            K1:      return 3'd1;
            K2:      return 3'd2;
            K3:      return 3'd3;
            K4:      return 3'd4;
            K5:      return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_window_feeder_row_buffer.sv
// Five-slot ifmap row buffer: K-aware shift-in of a new row and a
// column-select read returning one bit per slot (slots >= K read as 0).
module alu_row_buffer #(
    parameter int MAP_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [2:0]       k,
    input  logic [MAP_W-1:0] row_in,
    input  logic [CNT_W-1:0] col,
    output logic [4:0]       col_bits
);

    logic [MAP_W-1:0] slot [5];
    logic [MAP_W-1:0] sh   [5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 5; i++) slot[i] <= '0;
        end else if (shift_en) begin
            // Only the K active slots move; the newest row lands in slot K-1.
            for (int unsigned i = 0; i < 4; i++) begin
                if (i + 1 < 32'(k)) slot[i] <= slot[i+1];
            end
            for (int unsigned i = 0; i < 5; i++) begin
                if (i + 1 == 32'(k)) slot[i] <= row_in;
            end
        end
    end

    always_comb begin
        col_bits = '0;
        for (int unsigned r = 0; r < 5; r++) begin
            sh[r] = slot[r] >> col;
            if (r < 32'(k)) col_bits[r] = sh[r][0];
        end
    end

endmodule

// File: rtl/alu_window_feeder.sv
// Producer-side sequencer for the binary conv/pooling ALU: takes a config,
// a weight kernel and ifmap rows, and streams columns into the ALU.
module alu_window_feeder
    import alu_feeder_pkg::*;
#(
    parameter int MAP_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [4:0]       cfg_kernel_size,
    input  logic             cfg_operation,
    input  logic [CNT_W-1:0] cfg_map_w,
    input  logic [CNT_W-1:0] cfg_map_h,
    input  logic [24:0]      weight_data,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic [MAP_W-1:0] row_data,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             ifmaps_row0_out,
    output logic             ifmaps_row1_out,
    output logic             ifmaps_row2_out,
    output logic             ifmaps_row3_out,
    output logic             ifmaps_row4_out,
    output logic [24:0]      weight_out,
    output logic             load_ifmaps,
    output logic             load_weight,
    output logic             operation,
    output logic [4:0]       kernel_size,
    output logic             mac_valid,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    feeder_state_t state, nxt;

    logic [CNT_W-1:0] map_w_q, map_h_q;
    logic [CNT_W-1:0] col, rows_acc, cur_row;
    logic [2:0]       fill_cnt;
    logic [2:0]       k_dim;
    logic [CNT_W-1:0] k_m1;
    logic [4:0]       rd_bits;
    logic [4:0]       ifm_q;
    logic             row_acc, w_acc, cfg_bad, last_col;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_col, pend_row;

    assign k_dim    = kernel_dim(kernel_size);
    assign k_m1     = CNT_W'(k_dim) - CNT_W'(1);
    assign last_col = (col == map_w_q - CNT_W'(1));
    assign cfg_bad  = !onehot_ok(kernel_size)
                   || (CNT_W'(k_dim) > map_w_q)
                   || (CNT_W'(k_dim) > map_h_q)
                   || (map_w_q > CNT_W'(MAP_W))
                   || (map_w_q == '0);

    assign ifmaps_row0_out = ifm_q[0];
    assign ifmaps_row1_out = ifm_q[1];
    assign ifmaps_row2_out = ifm_q[2];
    assign ifmaps_row3_out = ifm_q[3];
    assign ifmaps_row4_out = ifm_q[4];

    alu_row_buffer #(
        .MAP_W (MAP_W),
        .CNT_W (CNT_W)
    ) u_row_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (row_acc),
        .k        (k_dim),
        .row_in   (row_data),
        .col      (col),
        .col_bits (rd_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        row_acc = 1'b0;
        w_acc   = 1'b0;
        case (state)
            IDLE:   if (cfg_start) nxt = CHECK;
            CHECK: begin
                if (cfg_bad)         nxt = IDLE;
                else if (!operation) nxt = LOAD_W;
                else                 nxt = FILL;
            end
            LOAD_W: begin
                if (weight_valid && weight_ready) begin
                    w_acc = 1'b1;
                    nxt   = FILL;
                end
            end
            FILL: begin
                if (row_valid && row_ready) begin
                    row_acc = 1'b1;
                    if (fill_cnt + 3'd1 == k_dim) nxt = STREAM;
                end
            end
            STREAM: begin
                if (last_col) nxt = (rows_acc < map_h_q) ? NEXT_ROW : DONE;
            end
            NEXT_ROW: begin
                if (row_valid && row_ready) begin
                    row_acc = 1'b1;
                    nxt     = STREAM;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Handshake readies are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_ready <= 1'b0;
            row_ready    <= 1'b0;
            ifm_q        <= '0;
            weight_out   <= '1;
            load_ifmaps  <= 1'b0;
            load_weight  <= 1'b0;
            operation    <= 1'b0;
            kernel_size  <= '0;
            mac_valid    <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            map_w_q      <= '0;
            map_h_q      <= '0;
            col          <= '0;
            rows_acc     <= '0;
            cur_row      <= '0;
            fill_cnt     <= '0;
            pend_valid   <= 1'b0;
            pend_col     <= '0;
            pend_row     <= '0;
        end else begin
            weight_ready <= (nxt == LOAD_W);
            row_ready    <= (nxt == FILL) || (nxt == NEXT_ROW);
            busy         <= (nxt != IDLE);
            done         <= (state == DONE);
            cfg_err      <= (state == CHECK) && cfg_bad;
            load_weight  <= w_acc;
            load_ifmaps  <= 1'b0;
            pend_valid   <= 1'b0;
            mac_valid    <= pend_valid;

            if (pend_valid) begin
                out_row <= pend_row;
                out_col <= pend_col;
            end

            if (state == IDLE && cfg_start) begin
                kernel_size <= cfg_kernel_size;
                operation   <= cfg_operation;
                map_w_q     <= cfg_map_w;
                map_h_q     <= cfg_map_h;
            end

            if (state == CHECK) begin
                col      <= '0;
                rows_acc <= '0;
                cur_row  <= '0;
                fill_cnt <= '0;
            end

            if (w_acc) weight_out <= weight_data;

            if (row_acc) begin
                rows_acc <= rows_acc + CNT_W'(1);
                if (state == FILL)     fill_cnt <= fill_cnt + 3'd1;
                if (state == NEXT_ROW) cur_row  <= cur_row + CNT_W'(1);
            end

            // A window result is flagged one cycle after the load that completes it.
            if (state == STREAM) begin
                load_ifmaps <= 1'b1;
                ifm_q       <= rd_bits;
                pend_valid  <= (col >= k_m1);
                pend_col    <= col - k_m1;
                pend_row    <= cur_row;
                col         <= last_col ? '0 : col + CNT_W'(1);
            end
        end
    end

endmodule
